mem_write_checker: RTL and testbench
====================================

Name: mem_write_checker

Overview:
Synthesizable in-order checker for the processor's data-memory write bus (MemWrite, DataAdr, WriteData). The checker is loaded with a queue of expected (address, data) writes, then watches the core and reports pass or fail with diagnostics. It is generalised in data/address width, queue depth and match strictness. It sits beside `top` in simulation and FPGA self-test builds, so pass/fail can drive an LED or be sampled by the bench.

Parameters:
DATA_W, 32, width of WriteData and expected data
ADDR_W, 32, width of DataAdr and expected address
DEPTH, 8, expectation queue entries (power of 2, >=2)
STRICT, 0, 0 = writes to non-head addresses are ignored and counted; 1 = any non-head-address write is a failure
TIMEOUT_CYCLES, 1000, RUN cycles allowed without a match (used only with WCHK_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
clear  in  1  synchronous pulse: flush queue, counters, return to IDLE
load_valid  in  1  expectation entry present
load_ready  out  1  entry accepted when load_valid & load_ready
load_adr  in  ADDR_W  expected address
load_data  in  DATA_W  expected data
start  in  1  pulse: begin checking
MemWrite  in  1  core write strobe
DataAdr  in  ADDR_W  core write address
WriteData  in  DATA_W  core write data
busy  out  1  state==RUN
done  out  1  state in {PASS, FAIL}
pass  out  1  all expected writes matched
fail  out  1  mismatch or timeout
timed_out  out  1  failure cause was timeout
fail_index  out  $clog2(DEPTH)  queue index of offending entry
err_adr  out  ADDR_W  DataAdr captured at failure
err_data  out  DATA_W  WriteData captured at failure
match_cnt  out  $clog2(DEPTH+1)  entries matched so far
ignored_cnt  out  16  non-head writes ignored (saturates at 0xFFFF)

Behaviour:
- Clock is clk; reset is asynchronous, active-high. On reset all outputs are 0, the queue is empty, and state is IDLE.
- States are IDLE, RUN, PASS and FAIL. All outputs are registered.
- IDLE:
  - load_ready = !full. Each accepted load is written at the write pointer; pointers wrap modulo DEPTH.
  - start with a non-empty queue goes to RUN. start with an empty queue goes to PASS.
  - MemWrite is ignored.
- RUN: MemWrite is sampled at each rising clk.
  - DataAdr==head_adr and WriteData==head_data: pop the head and increment match_cnt. If the queue becomes empty, go to PASS.
  - DataAdr==head_adr and data differs: go to FAIL. Capture err_adr, err_data, and fail_index = number of entries already popped.
  - DataAdr!=head_adr: with STRICT=0, increment ignored_cnt and stay in RUN. With STRICT=1, go to FAIL and capture as above.
  - load_ready=0 throughout RUN. start is ignored.
- Latency: done, pass and fail assert on the cycle after the rising edge that sampled the deciding write.
- PASS and FAIL are sticky until clear or reset.
- clear returns from any state to IDLE, empties the queue and zeroes all counters and error registers. clear beats start when both are asserted in the same cycle.
- load_valid while full: not accepted, no overwrite.
- Reset during RUN aborts immediately. pass and fail stay 0.
- Address and data compares are exact across the full ADDR_W and DATA_W. X/Z inputs are not special-cased.

Optional Feature:
WCHK_TIMEOUT_EN
- Defined: a cycle counter runs in RUN and clears on every match. When it reaches TIMEOUT_CYCLES, go to FAIL with timed_out=1, fail_index = current head index, and err_adr/err_data = 0.
- Undefined: no counter is built, timed_out is tied to 0, and RUN can last indefinitely.

Decomposition:
- Package wchk_pkg holds:
  - the state enum (IDLE, RUN, PASS, FAIL);
  - the counter width constant IGN_W=16;
  - helper localparams for pointer width.
- Sub-module wchk_fifo: a synchronous DEPTH x (ADDR_W+DATA_W) queue. It has push, pop, flush, full, empty and head outputs, and a wrap-around read/write pointer pair with an extra MSB to distinguish full from empty.
- The checker FSM and counters stay in mem_write_checker.

Test Plan:
- Load (128,254), start, then MemWrite DataAdr=128 WriteData=254 → next cycle pass=1, done=1, match_cnt=1.
- Load (128,254), start, then write 128/255 → fail=1, err_adr=128, err_data=255, fail_index=0, pass=0.
- STRICT=0: load (128,254), start, write 100/7, then write 128/254 → ignored_cnt=1, pass=1. With STRICT=1, the same stimulus gives fail after the 100/7 write with err_adr=100.
- DEPTH=4: offer 5 loads → load_ready drops after 4th accept; 5th entry absent. Then 4 correct writes → pass=1 and match_cnt=4.
- Mid-RUN reset after 1 of 3 matches → all outputs 0 immediately, state IDLE, queue empty. Also: clear+start in the same cycle → stays IDLE.
- WCHK_TIMEOUT_EN with TIMEOUT_CYCLES=20: start and send no writes → fail=1 and timed_out=1 exactly 20 cycles after entering RUN. Without the macro, after 100 cycles busy is still 1 and timed_out=0.

Source files
------------

// File: rtl/wchk_pkg.sv
// -----------------------------------------------------------------------------
// wchk_pkg
// Shared types and constants for the data-memory write checker:
//   wchk_state_e : checker FSM states (IDLE, RUN, PASS, FAIL)
//   IGN_W        : width of the saturating ignored-write counter
//   ptr_w()      : index width for a queue of a given depth
// -----------------------------------------------------------------------------
package wchk_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PASS = 2'd2,
      S_FAIL = 2'd3
   } wchk_state_e;

   localparam int unsigned IGN_W = 16;

   // Index width for a power-of-two queue; never narrower than one bit.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// -----------------------------------------------------------------------------
// mem_write_checker_if
// Bundles the expectation-load handshake and the core data-memory write bus.
//   load_valid/load_ready/load_adr/load_data : expectation entry handshake
//   MemWrite/DataAdr/WriteData               : core write strobe, address, data
// Modports:
//   master : stimulus side (loader + core), drives everything but load_ready
//   slave  : checker side, drives load_ready
// -----------------------------------------------------------------------------
interface mem_write_checker_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic              load_valid;
   logic              load_ready;
   logic [ADDR_W-1:0] load_adr;
   logic [DATA_W-1:0] load_data;
   logic              MemWrite;
   logic [ADDR_W-1:0] DataAdr;
   logic [DATA_W-1:0] WriteData;

   modport master (
      output load_valid, load_adr, load_data, MemWrite, DataAdr, WriteData,
      input  load_ready
   );

   modport slave (
      input  load_valid, load_adr, load_data, MemWrite, DataAdr, WriteData,
      output load_ready
   );

endinterface

// File: rtl/wchk_fifo.sv
// -----------------------------------------------------------------------------
// wchk_fifo
// Synchronous DEPTH x W queue holding expected (address, data) writes.
// Read/write pointers carry one extra MSB so full and empty are distinct.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (pointers only)
//   flush        : synchronous empty; wins over push/pop in the same cycle
//   push, wdata  : enqueue (ignored while full)
//   pop          : dequeue head (ignored while empty)
//   head         : entry at the read pointer
//   full, empty  : current occupancy flags
//   full_nxt     : full flag as it will be after this cycle's push/pop/flush
//   count        : current number of entries
// -----------------------------------------------------------------------------
module wchk_fifo
   import wchk_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic                     full_nxt,
   output logic [ptr_w(DEPTH):0]    count
);

   localparam int unsigned AW = ptr_w(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         push_ok, pop_ok;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

   assign head     = mem_q[rd_ptr_q[AW-1:0]];
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign full_nxt = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                     (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   assign count    = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/mem_write_checker.sv
// -----------------------------------------------------------------------------
// mem_write_checker
// In-order checker for the core's data-memory write bus. A queue of expected
// (address, data) writes is loaded in IDLE; after start, each core write is
// compared against the queue head. All outputs are registered.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : synchronous flush of queue, counters, errors; back to IDLE
//   start        : pulse to begin checking (empty queue -> immediate PASS)
//   bus          : load handshake + MemWrite/DataAdr/WriteData (slave modport)
//   busy/done    : RUN / PASS-or-FAIL
//   pass/fail    : verdict, sticky until clear or reset
//   timed_out    : failure was caused by the RUN timeout
//   fail_index   : queue index of the offending entry
//   err_adr/data : write captured at failure
//   match_cnt    : entries matched so far
//   ignored_cnt  : non-head writes ignored (STRICT=0), saturating
// Build option: define WCHK_TIMEOUT_EN to fail after TIMEOUT_CYCLES RUN cycles
// without a match; otherwise RUN may last indefinitely and timed_out is 0.
// -----------------------------------------------------------------------------
module mem_write_checker
   import wchk_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DEPTH          = 8,
   parameter int unsigned STRICT         = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         start,
   mem_write_checker_if.slave           bus,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic                         fail,
   output logic                         timed_out,
   output logic [$clog2(DEPTH)-1:0]     fail_index,
   output logic [ADDR_W-1:0]            err_adr,
   output logic [DATA_W-1:0]            err_data,
   output logic [$clog2(DEPTH+1)-1:0]   match_cnt,
   output logic [IGN_W-1:0]             ignored_cnt
);

   localparam int unsigned AW  = ptr_w(DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned FIW = $clog2(DEPTH);
   localparam int unsigned MCW = $clog2(DEPTH + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mem_write_checker: DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("mem_write_checker: TIMEOUT_CYCLES must be non-zero");
   end

   wchk_state_e             state_q, state_d;
   logic                    load_ready_q, load_ready_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic                    fail_q, fail_d;
   logic                    timed_out_q, timed_out_d;
   logic [FIW-1:0]          fail_index_q, fail_index_d;
   logic [ADDR_W-1:0]       err_adr_q, err_adr_d;
   logic [DATA_W-1:0]       err_data_q, err_data_d;
   logic [MCW-1:0]          match_cnt_q, match_cnt_d;
   logic [IGN_W-1:0]        ignored_cnt_q, ignored_cnt_d;

   logic                    fifo_push, fifo_pop;
   logic                    fifo_full, fifo_empty, fifo_full_nxt;
   logic [CW-1:0]           fifo_count;
   logic [ADDR_W+DATA_W-1:0] fifo_head;
   logic [ADDR_W-1:0]       head_adr;
   logic [DATA_W-1:0]       head_data;
   logic                    hit_adr, hit_data;

   wchk_fifo #(
      .DEPTH (DEPTH),
      .W     (ADDR_W + DATA_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (clear),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .wdata    ({bus.load_adr, bus.load_data}),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .full_nxt (fifo_full_nxt),
      .count    (fifo_count)
   );

   assign head_adr  = fifo_head[ADDR_W+DATA_W-1 -: ADDR_W];
   assign head_data = fifo_head[DATA_W-1:0];
   assign hit_adr   = (bus.DataAdr == head_adr);
   assign hit_data  = (bus.WriteData == head_data);

   // load_ready_q is only ever 1 in IDLE, so it alone qualifies the push.
   assign fifo_push    = bus.load_valid & load_ready_q & ~fifo_full;
   // Registered ready looks ahead at the queue state after this cycle.
   assign load_ready_d = (state_d == S_IDLE) & ~fifo_full_nxt;

`ifdef WCHK_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

   always_comb begin
      state_d       = state_q;
      timed_out_d   = timed_out_q;
      fail_index_d  = fail_index_q;
      err_adr_d     = err_adr_q;
      err_data_d    = err_data_q;
      match_cnt_d   = match_cnt_q;
      ignored_cnt_d = ignored_cnt_q;
      fifo_pop      = 1'b0;
`ifdef WCHK_TIMEOUT_EN
      tmo_cnt_d     = '0;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = fifo_empty ? S_PASS : S_RUN;
         end
         S_RUN: begin
`ifdef WCHK_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
            if (bus.MemWrite && hit_adr && hit_data) begin
               fifo_pop    = 1'b1;
               match_cnt_d = match_cnt_q + MCW'(1);
`ifdef WCHK_TIMEOUT_EN
               tmo_cnt_d   = '0;
`endif
               if (fifo_count == CW'(1)) state_d = S_PASS;
            end else if (bus.MemWrite && (hit_adr || STRICT != 0)) begin
               // Pointers restart at 0 on every clear/reset, so the number of
               // pops equals the head slot index.
               state_d      = S_FAIL;
               fail_index_d = match_cnt_q[FIW-1:0];
               err_adr_d    = bus.DataAdr;
               err_data_d   = bus.WriteData;
            end else begin
               if (bus.MemWrite && ignored_cnt_q != '1)
                  ignored_cnt_d = ignored_cnt_q + 1'b1;
`ifdef WCHK_TIMEOUT_EN
               if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  state_d      = S_FAIL;
                  timed_out_d  = 1'b1;
                  fail_index_d = match_cnt_q[FIW-1:0];
                  err_adr_d    = '0;
                  err_data_d   = '0;
               end
`endif
            end
         end
         default: ;
      endcase

      if (clear) begin
         state_d       = S_IDLE;
         timed_out_d   = 1'b0;
         fail_index_d  = '0;
         err_adr_d     = '0;
         err_data_d    = '0;
         match_cnt_d   = '0;
         ignored_cnt_d = '0;
         fifo_pop      = 1'b0;
`ifdef WCHK_TIMEOUT_EN
         tmo_cnt_d     = '0;
`endif
      end

      busy_d = (state_d == S_RUN);
      pass_d = (state_d == S_PASS);
      fail_d = (state_d == S_FAIL);
      done_d = pass_d | fail_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         load_ready_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         fail_q        <= 1'b0;
         timed_out_q   <= 1'b0;
         fail_index_q  <= '0;
         err_adr_q     <= '0;
         err_data_q    <= '0;
         match_cnt_q   <= '0;
         ignored_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         load_ready_q  <= load_ready_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         fail_q        <= fail_d;
         timed_out_q   <= timed_out_d;
         fail_index_q  <= fail_index_d;
         err_adr_q     <= err_adr_d;
         err_data_q    <= err_data_d;
         match_cnt_q   <= match_cnt_d;
         ignored_cnt_q <= ignored_cnt_d;
      end
   end

`ifdef WCHK_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tmo_cnt_q <= '0;
      else       tmo_cnt_q <= tmo_cnt_d;
   end
`endif

   assign bus.load_ready = load_ready_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign fail           = fail_q;
   assign timed_out      = timed_out_q;
   assign fail_index     = fail_index_q;
   assign err_adr        = err_adr_q;
   assign err_data       = err_data_q;
   assign match_cnt      = match_cnt_q;
   assign ignored_cnt    = ignored_cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// -----------------------------------------------------------------------------
// tb_mem_write_checker
// Two checkers share one stimulus stream: u0 (DEPTH=8, lenient) and
// u1 (DEPTH=4, strict). Expected verdicts come from an in-order list model
// and are queued per instance; monitors compare when done rises.
// -----------------------------------------------------------------------------
module tb_mem_write_checker;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned D0  = 8;
   localparam int unsigned D1  = 4;
   localparam int unsigned TMO = 20;

   logic clk = 1'b0;
   logic reset, clear, start;
   always #5 clk = ~clk;

   mem_write_checker_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
   mem_write_checker_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

   logic          busy0, done0, pass0, fail0, tmo0;
   logic [2:0]    fidx0;
   logic [AW-1:0] eadr0;
   logic [DW-1:0] edat0;
   logic [3:0]    mcnt0;
   logic [15:0]   ign0;
   logic          busy1, done1, pass1, fail1, tmo1;
   logic [1:0]    fidx1;
   logic [AW-1:0] eadr1;
   logic [DW-1:0] edat1;
   logic [2:0]    mcnt1;
   logic [15:0]   ign1;

   mem_write_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D0), .STRICT(0), .TIMEOUT_CYCLES(TMO)) u0 (
      .clk(clk), .reset(reset), .clear(clear), .start(start), .bus(b0),
      .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .timed_out(tmo0),
      .fail_index(fidx0), .err_adr(eadr0), .err_data(edat0),
      .match_cnt(mcnt0), .ignored_cnt(ign0));

   mem_write_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D1), .STRICT(1), .TIMEOUT_CYCLES(TMO)) u1 (
      .clk(clk), .reset(reset), .clear(clear), .start(start), .bus(b1),
      .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .timed_out(tmo1),
      .fail_index(fidx1), .err_adr(eadr1), .err_data(edat1),
      .match_cnt(mcnt1), .ignored_cnt(ign1));

   typedef struct {
      bit              pass;
      bit              fl;
      bit              tmo;
      int unsigned     fidx;
      int unsigned     mcnt;
      int unsigned     icnt;
      logic [AW-1:0]   eadr;
      logic [DW-1:0]   edat;
   } res_t;

   res_t sb0[$], sb1[$];
   int   checks = 0;
   int   errors = 0;

   logic [AW-1:0] ent_adr[$];
   logic [DW-1:0] ent_dat[$];
   logic [AW-1:0] wr_adr[$];
   logic [DW-1:0] wr_dat[$];
   bit            wr_en[$];

   // In-order reference: walk the write list against the first min(n,depth)
   // expectations. Returns 1 when a verdict is reached.
   function automatic bit model(input int unsigned depth, input bit strict, output res_t r);
      int unsigned n, h;
      n = (ent_adr.size() < depth) ? ent_adr.size() : depth;
      r.pass = 0; r.fl = 0; r.tmo = 0; r.fidx = 0; r.mcnt = 0; r.icnt = 0;
      r.eadr = '0; r.edat = '0;
      if (n == 0) begin
         r.pass = 1;
         return 1'b1;
      end
      h = 0;
      for (int k = 0; k < wr_adr.size(); k++) begin
         if (!wr_en[k]) continue;
         if (wr_adr[k] == ent_adr[h] && wr_dat[k] == ent_dat[h]) begin
            h++;
            r.mcnt = h;
            if (h == n) begin
               r.pass = 1;
               return 1'b1;
            end
         end else if (wr_adr[k] == ent_adr[h] || strict) begin
            r.fl = 1; r.fidx = h; r.eadr = wr_adr[k]; r.edat = wr_dat[k];
            return 1'b1;
         end else begin
            r.icnt++;
         end
      end
      return 1'b0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic cmp_res(input string nm, input res_t a, input res_t e);
      checks++;
      if (a.pass !== e.pass || a.fl !== e.fl || a.tmo !== e.tmo || a.fidx != e.fidx ||
          a.mcnt != e.mcnt || a.icnt != e.icnt || a.eadr !== e.eadr || a.edat !== e.edat) begin
         errors++;
         $display("FAIL %s actual pass=%0d fail=%0d tmo=%0d fidx=%0d mcnt=%0d icnt=%0d adr=%0h dat=%0h required pass=%0d fail=%0d tmo=%0d fidx=%0d mcnt=%0d icnt=%0d adr=%0h dat=%0h",
                  nm, a.pass, a.fl, a.tmo, a.fidx, a.mcnt, a.icnt, a.eadr, a.edat,
                  e.pass, e.fl, e.tmo, e.fidx, e.mcnt, e.icnt, e.eadr, e.edat);
      end
   endtask

   // Monitors: one verdict expected per rising edge of done.
   logic pd0 = 1'b0, pd1 = 1'b0;
   always @(negedge clk) begin
      res_t a, e;
      if (done0 && !pd0) begin
         if (sb0.size() == 0) begin
            checks++; errors++;
            $display("FAIL u0_unexpected_done actual=1 required=0");
         end else begin
            a.pass = pass0; a.fl = fail0; a.tmo = tmo0; a.fidx = fidx0; a.mcnt = mcnt0;
            a.icnt = ign0; a.eadr = eadr0; a.edat = edat0;
            e = sb0.pop_front();
            cmp_res("u0_verdict", a, e);
         end
      end
      pd0 <= done0;
   end
   always @(negedge clk) begin
      res_t a, e;
      if (done1 && !pd1) begin
         if (sb1.size() == 0) begin
            checks++; errors++;
            $display("FAIL u1_unexpected_done actual=1 required=0");
         end else begin
            a.pass = pass1; a.fl = fail1; a.tmo = tmo1; a.fidx = fidx1; a.mcnt = mcnt1;
            a.icnt = ign1; a.eadr = eadr1; a.edat = edat1;
            e = sb1.pop_front();
            cmp_res("u1_verdict", a, e);
         end
      end
      pd1 <= done1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input logic mw, input logic [AW-1:0] da, input logic [DW-1:0] wd);
      b0.load_valid = lv; b0.load_adr = la; b0.load_data = ld;
      b0.MemWrite = mw; b0.DataAdr = da; b0.WriteData = wd;
      b1.load_valid = lv; b1.load_adr = la; b1.load_data = ld;
      b1.MemWrite = mw; b1.DataAdr = da; b1.WriteData = wd;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_flags0"}, {busy0, done0, pass0, fail0, tmo0, b0.load_ready}, 0);
      chk({tag, "_flags1"}, {busy1, done1, pass1, fail1, tmo1, b1.load_ready}, 0);
      chk({tag, "_cnt0"}, {fidx0, mcnt0, ign0}, 0);
      chk({tag, "_cnt1"}, {fidx1, mcnt1, ign1}, 0);
      chk({tag, "_err0"}, {eadr0, edat0}, 0);
      chk({tag, "_err1"}, {eadr1, edat1}, 0);
   endtask

   // Clear, then offer every entry of ent_* once (one per cycle).
   task automatic load_phase();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      for (int i = 0; i < ent_adr.size(); i++) begin
         drv(1'b1, ent_adr[i], ent_dat[i], 1'($urandom_range(0, 1)), $urandom, $urandom);
         @(negedge clk);
         chk("load_ready0", b0.load_ready, (i < D0) ? 1 : 0);
         chk("load_ready1", b1.load_ready, (i < D1) ? 1 : 0);
         tick();
      end
      drv(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   // Start, replay wr_*, then confirm each instance is decided or still busy.
   task automatic run_phase();
      res_t r0, r1;
      bit   d0, d1;
      d0 = model(D0, 1'b0, r0);
      d1 = model(D1, 1'b1, r1);
      if (d0) sb0.push_back(r0);
      if (d1) sb1.push_back(r1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < wr_adr.size(); k++) begin
         drv(1'b0, '0, '0, wr_en[k], wr_adr[k], wr_dat[k]);
         tick();
      end
      drv(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
      @(negedge clk);
      chk("done0", done0, d0);
      chk("busy0", busy0, !d0);
      chk("done1", done1, d1);
      chk("busy1", busy1, !d1);
      if (!done0) sb0.delete();
      if (!done1) sb1.delete();
   endtask

   task automatic add_ent(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ent_adr.push_back(a);
      ent_dat.push_back(d);
   endtask

   task automatic add_wr(input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en.push_back(en);
      wr_adr.push_back(a);
      wr_dat.push_back(d);
   endtask

   task automatic reset_lists();
      ent_adr.delete(); ent_dat.delete();
      wr_adr.delete(); wr_dat.delete(); wr_en.delete();
   endtask

   initial begin
      int unsigned n, nw, j, c, c0, c1;
      reset = 1'b1; clear = 1'b0; start = 1'b0;
      drv(1'b0, '0, '0, 1'b0, '0, '0);
      #2;
      chk_zero("reset");
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Exact match of a single entry.
      reset_lists();
      add_ent(128, 254);
      add_wr(1, 128, 254);
      load_phase(); run_phase();

      // Same address, wrong data.
      reset_lists();
      add_ent(128, 254);
      add_wr(1, 128, 255);
      load_phase(); run_phase();

      // Non-head write: ignored by u0, fatal for u1.
      reset_lists();
      add_ent(128, 254);
      add_wr(1, 100, 7);
      add_wr(1, 128, 254);
      load_phase(); run_phase();

      // Five loads against DEPTH=4; u1 keeps four, u0 keeps five.
      reset_lists();
      for (int i = 0; i < 5; i++) add_ent(32'h40 + 4 * i, 32'hA0 + i);
      for (int i = 0; i < 4; i++) add_wr(1, 32'h40 + 4 * i, 32'hA0 + i);
      load_phase(); run_phase();
      chk("u1_match4", mcnt1, 4);

      // Reset while running, after one of three matches.
      reset_lists();
      for (int i = 0; i < 3; i++) add_ent(32'h200 + i, 32'h55 + i);
      add_wr(1, 32'h200, 32'h55);
      load_phase(); run_phase();
      chk("midrun_mcnt0", mcnt0, 1);
      reset = 1'b1;
      #1;
      chk_zero("midrun_reset");
      tick();
      reset = 1'b0;
      tick();
      reset_lists();
      run_phase();

      // clear and start together: stays in IDLE with the queue flushed.
      reset_lists();
      add_ent(32'h10, 32'h11);
      add_ent(32'h14, 32'h12);
      load_phase();
      clear = 1'b1; start = 1'b1;
      tick();
      clear = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("clrstart_busy", {busy0, busy1}, 0);
      chk("clrstart_done", {done0, done1}, 0);
      chk("clrstart_ready", {b0.load_ready, b1.load_ready}, 2'b11);
      tick();
      reset_lists();
      run_phase();

      // One match, then silence on the bus.
      reset_lists();
      add_ent(32'h300, 32'h1);
      add_ent(32'h304, 32'h2);
      load_phase();
      start = 1'b1;
      tick();
      start = 1'b0;
`ifdef WCHK_TIMEOUT_EN
      begin
         res_t rt;
         rt.pass = 0; rt.fl = 1; rt.tmo = 1; rt.fidx = 1; rt.mcnt = 1; rt.icnt = 0;
         rt.eadr = '0; rt.edat = '0;
         sb0.push_back(rt);
         sb1.push_back(rt);
      end
`endif
      drv(1'b0, '0, '0, 1'b1, 32'h300, 32'h1);
      tick();
      drv(1'b0, '0, '0, 1'b0, '0, '0);
`ifdef WCHK_TIMEOUT_EN
      c0 = 0; c1 = 0;
      for (c = 0; c < 60; c++) begin
         @(negedge clk);
         if (fail0 && c0 == 0) c0 = c;
         if (fail1 && c1 == 0) c1 = c;
         if (c0 != 0 && c1 != 0) break;
      end
      chk("tmo_latency0", c0, TMO);
      chk("tmo_latency1", c1, TMO);
      chk("tmo_flag", {tmo0, tmo1}, 2'b11);
`else
      c0 = 0; c1 = 0;
      for (c = 0; c < 100; c++) @(negedge clk);
      chk("no_tmo_busy", {busy0, busy1}, 2'b11);
      chk("no_tmo_flag", {tmo0, tmo1}, 0);
`endif
      tick();

      // Randomized scenarios against the list model.
      for (int s = 0; s < 40; s++) begin
         reset_lists();
         n = $urandom_range(0, 10);
         for (int i = 0; i < n; i++) add_ent({26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
         nw = $urandom_range(4, 12);
         j = 0;
         for (int k = 0; k < nw; k++) begin
            c = $urandom_range(0, 9);
            if (c < 6 && j < n && j < D0) begin
               add_wr(1, ent_adr[j], ent_dat[j]);
               j++;
            end else if (c == 6 && j < n && j < D0) begin
               add_wr(1, ent_adr[j], ent_dat[j] ^ (32'd1 << $urandom_range(0, 31)));
            end else if (c == 9) begin
               add_wr(0, $urandom, $urandom);
            end else begin
               add_wr(1, {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
            end
         end
         load_phase(); run_phase();
      end

      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      chk("sb0_drained", sb0.size(), 0);
      chk("sb1_drained", sb1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
